// File: rtl/silly_resp_checker_pkg.sv
// Shared types and constants for the silly response checker.
package silly_chk_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} chk_state_t;

  typedef logic [2:0] vec_t;

  localparam int NUM_VEC = 8;
  localparam logic [NUM_VEC-1:0] ALL_SEEN = '1;

endpackage

// File: rtl/silly_resp_checker_if.sv
// Stimulus/response bundle between the vector source and the checker.
// Optional FIRST_FAIL_CAPTURE_EN adds the first-mismatch capture signals.
interface silly_resp_checker_if #(parameter int ERR_W = 4);
  import silly_chk_pkg::*;

  logic             clear;
  logic             vec_valid;
  vec_t             vec;
  logic             y;
  logic             z;
  logic             busy;
  logic             result_valid;
  logic             mismatch;
  logic [ERR_W-1:0] err_cnt;
  logic             overrun;
  logic             done;
  logic             pass;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic             fail_valid;
  vec_t             fail_vec;
  logic [1:0]       fail_yz;

  modport master (output clear, vec_valid, vec, y, z,
                  input  busy, result_valid, mismatch, err_cnt, overrun, done, pass,
                         fail_valid, fail_vec, fail_yz);
  modport slave  (input  clear, vec_valid, vec, y, z,
                  output busy, result_valid, mismatch, err_cnt, overrun, done, pass,
                         fail_valid, fail_vec, fail_yz);
`else
  modport master (output clear, vec_valid, vec, y, z,
                  input  busy, result_valid, mismatch, err_cnt, overrun, done, pass);
  modport slave  (input  clear, vec_valid, vec, y, z,
                  output busy, result_valid, mismatch, err_cnt, overrun, done, pass);
`endif

endinterface

// File: rtl/silly_resp_checker_settle_timer.sv
// Loadable 4-bit down-counter that times the settle window before sampling y/z.
module silly_chk_settle_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       run,
  output logic [3:0] value,
  output logic       expire
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign value  = cnt;
  assign expire = (cnt == 4'd1);

endmodule

// File: rtl/silly_resp_checker.sv
// Checks y/z against a golden truth table for each applied {a,b,c} vector.
// Define FIRST_FAIL_CAPTURE_EN to latch the first failing vector and response.
module silly_resp_checker
  import silly_chk_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] EXP_Y         = 8'hE8,
  parameter logic [7:0] EXP_Z         = 8'h96,
  parameter int         ERR_W         = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  silly_resp_checker_if.slave bus
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  chk_state_t         state, state_next;
  vec_t               vec_q;
  logic [NUM_VEC-1:0] seen;
  logic [NUM_VEC-1:0] seen_upd;
  logic [ERR_W-1:0]   err_cnt_q;
  logic               overrun_q;
  logic               accept;
  logic               in_sample;
  logic               diff;
  logic [3:0]         settle_val;
  logic               settle_expire;
  logic               settle_done;

  assign accept    = (state == IDLE) && bus.vec_valid && !bus.clear;
  assign in_sample = (state == SAMPLE) && !bus.clear;
  assign diff      = {bus.y, bus.z} != {EXP_Y[vec_q], EXP_Z[vec_q]};
  assign seen_upd  = seen | (NUM_VEC'(1) << vec_q);
  // A zero count in SETTLE cannot normally occur; leaving anyway avoids a lock-up.
  assign settle_done = settle_expire || (settle_val == 4'd0);

  silly_chk_settle_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (bus.clear),
    .load     (accept),
    .load_val (SETTLE_LD),
    .run      (state == SETTLE),
    .value    (settle_val),
    .expire   (settle_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.vec_valid) state_next = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        SETTLE:  if (settle_done) state_next = SAMPLE;
        SAMPLE:  state_next = (seen_upd == ALL_SEEN) ? DONE : IDLE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_q     <= '0;
      seen      <= '0;
      err_cnt_q <= '0;
      overrun_q <= 1'b0;
    end else if (bus.clear) begin
      vec_q     <= '0;
      seen      <= '0;
      err_cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) vec_q <= bus.vec;
      if (in_sample) begin
        seen <= seen_upd;
        if (diff && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      end
      // Any strobe outside IDLE is dropped and flagged.
      if (bus.vec_valid && state != IDLE) overrun_q <= 1'b1;
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  logic       fail_valid_q;
  vec_t       fail_vec_q;
  logic [1:0] fail_yz_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_yz_q    <= '0;
    end else if (bus.clear) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_yz_q    <= '0;
    end else if (in_sample && diff && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_vec_q   <= vec_q;
      fail_yz_q    <= {bus.y, bus.z};
    end
  end

  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_vec   = fail_vec_q;
  assign bus.fail_yz    = fail_yz_q;
`endif

  assign bus.busy         = (state == SETTLE) || (state == SAMPLE);
  assign bus.result_valid = in_sample;
  assign bus.mismatch     = in_sample && diff;
  assign bus.err_cnt      = err_cnt_q;
  assign bus.overrun      = overrun_q;
  assign bus.done         = (state == DONE);
  assign bus.pass         = (state == DONE) && (err_cnt_q == '0) && !overrun_q;

endmodule

// File: tb/tb_silly_resp_checker.sv
// Directed bench for silly_resp_checker: one SETTLE=2/ERR_W=4 instance and one SETTLE=0/ERR_W=2 instance.
module tb_silly_resp_checker;
  import silly_chk_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       clear_d = 1'b0;
  logic       valid_d = 1'b0;
  logic [2:0] vec_d = 3'd0;
  logic [2:0] cur_vec = 3'd0;
  logic       sel = 1'b0;
  logic       inv_y = 1'b0;
  int         inv_z_vec = -1;
  int         total = 0;
  int         bad = 0;
  int         rv_cnt = 0;
  logic       y_d, z_d;

  // Reference DUT: y = majority(a,b,c), z = a^b^c, with optional fault injection.
  assign y_d = ((cur_vec[2] & cur_vec[1]) | (cur_vec[2] & cur_vec[0]) | (cur_vec[1] & cur_vec[0])) ^ inv_y;
  assign z_d = (^cur_vec) ^ (inv_z_vec == int'(cur_vec));

  silly_resp_checker_if #(.ERR_W(4)) bus1();
  silly_resp_checker_if #(.ERR_W(2)) bus2();

  assign bus1.clear = clear_d;
  assign bus1.vec_valid = valid_d && !sel;
  assign bus1.vec = vec_d;
  assign bus1.y = y_d;
  assign bus1.z = z_d;
  assign bus2.clear = clear_d;
  assign bus2.vec_valid = valid_d && sel;
  assign bus2.vec = vec_d;
  assign bus2.y = y_d;
  assign bus2.z = z_d;

  silly_resp_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));
  silly_resp_checker #(.SETTLE_CYCLES(0), .ERR_W(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2.slave));

  logic       o_busy, o_rv, o_mis, o_ovr, o_done, o_pass;
  logic [3:0] o_err;
  assign o_busy = sel ? bus2.busy : bus1.busy;
  assign o_rv   = sel ? bus2.result_valid : bus1.result_valid;
  assign o_mis  = sel ? bus2.mismatch : bus1.mismatch;
  assign o_ovr  = sel ? bus2.overrun : bus1.overrun;
  assign o_done = sel ? bus2.done : bus1.done;
  assign o_pass = sel ? bus2.pass : bus1.pass;
  assign o_err  = sel ? {2'b00, bus2.err_cnt} : bus1.err_cnt;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkFlags(input string tag, input logic busy, input logic done, input logic pass,
                            input logic ovr, input logic [3:0] err);
    checkOutput({tag, ".busy"}, {7'd0, o_busy}, {7'd0, busy});
    checkOutput({tag, ".done"}, {7'd0, o_done}, {7'd0, done});
    checkOutput({tag, ".pass"}, {7'd0, o_pass}, {7'd0, pass});
    checkOutput({tag, ".overrun"}, {7'd0, o_ovr}, {7'd0, ovr});
    checkOutput({tag, ".err_cnt"}, {4'd0, o_err}, {4'd0, err});
  endtask

  // Applies one vector, optionally strobes a second one a cycle later, and waits for its result.
  task automatic applyStimulus(input logic [2:0] v, input logic exp_mis, input int exp_lat, input int overlap);
    int   lat;
    logic mis;
    lat = 0;
    mis = 1'b0;
    @(negedge clk);
    cur_vec = v;
    vec_d = v;
    valid_d = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      valid_d = 1'b0;
      if (k == 1 && overlap >= 0) begin
        vec_d = 3'(overlap);
        valid_d = 1'b1;
      end
      if (o_rv) begin
        lat = k;
        mis = o_mis;
        rv_cnt++;
        break;
      end
    end
    valid_d = 1'b0;
    checkOutput($sformatf("lat.v%0d", v), 8'(lat), 8'(exp_lat));
    checkOutput($sformatf("mis.v%0d", v), {7'd0, mis}, {7'd0, exp_mis});
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear_d = 1'b1;
    @(negedge clk);
    clear_d = 1'b0;
  endtask

  initial begin
    int rv_start;
    #12;
    checkFlags("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("reset.rv", {7'd0, o_rv}, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Clean sweep: every result three cycles after its strobe, full pass.
    for (int i = 0; i < 8; i++) applyStimulus(3'(i), 1'b0, 3, -1);
    @(negedge clk);
    checkFlags("sweep", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

    // z inverted on vector 3 only.
    pulseClear();
    inv_z_vec = 3;
    for (int i = 0; i < 8; i++) applyStimulus(3'(i), i == 3, 3, -1);
    @(negedge clk);
    checkFlags("zfault", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
`ifdef FIRST_FAIL_CAPTURE_EN
    checkOutput("fail_valid", {7'd0, bus1.fail_valid}, 8'd1);
    checkOutput("fail_vec", {5'd0, bus1.fail_vec}, 8'd3);
    checkOutput("fail_yz", {6'd0, bus1.fail_yz}, 8'd3);
`endif
    inv_z_vec = -1;
    pulseClear();
    checkFlags("clear_done", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
    checkOutput("fail_valid.clr", {7'd0, bus1.fail_valid}, 8'd0);
`endif

    // Overlapping strobe of vector 7 is dropped, so coverage is incomplete until 7 is really applied.
    applyStimulus(3'd0, 1'b0, 3, 7);
    checkOutput("ovr.set", {7'd0, o_ovr}, 8'd1);
    for (int i = 1; i < 7; i++) applyStimulus(3'(i), 1'b0, 3, -1);
    @(negedge clk);
    checkOutput("ovr.not_done", {7'd0, o_done}, 8'd0);
    applyStimulus(3'd7, 1'b0, 3, -1);
    @(negedge clk);
    checkFlags("ovr.end", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);

    // Repeated vector: nine results, done only after the ninth.
    pulseClear();
    rv_start = rv_cnt;
    applyStimulus(3'd5, 1'b0, 3, -1);
    applyStimulus(3'd5, 1'b0, 3, -1);
    for (int i = 0; i < 5; i++) applyStimulus(3'(i), 1'b0, 3, -1);
    applyStimulus(3'd6, 1'b0, 3, -1);
    @(negedge clk);
    checkOutput("rep.not_done", {7'd0, o_done}, 8'd0);
    applyStimulus(3'd7, 1'b0, 3, -1);
    @(negedge clk);
    checkOutput("rep.pulses", 8'(rv_cnt - rv_start), 8'd9);
    checkFlags("rep.end", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

    // Reset mid-SETTLE after an error has been counted.
    pulseClear();
    inv_z_vec = 0;
    applyStimulus(3'd0, 1'b1, 3, -1);
    inv_z_vec = -1;
    @(negedge clk);
    cur_vec = 3'd1;
    vec_d = 3'd1;
    valid_d = 1'b1;
    @(negedge clk);
    valid_d = 1'b0;
    checkOutput("abort.busy_pre", {7'd0, o_busy}, 8'd1);
    #2 reset_n = 1'b0;
    #1;
    checkFlags("abort", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rv_start = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (o_rv) rv_start++;
      if (k == 2) reset_n = 1'b1;
    end
    checkOutput("abort.no_rv", 8'(rv_start), 8'd0);
    for (int i = 0; i < 8; i++) applyStimulus(3'(7 - i), 1'b0, 3, -1);
    @(negedge clk);
    checkFlags("resweep", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

    // Second instance: zero settle and a 2-bit saturating error counter with y always wrong.
    sel = 1'b1;
    inv_y = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'(i), 1'b1, 1, -1);
      @(negedge clk);
      checkOutput($sformatf("sat.err%0d", i), {4'd0, o_err}, (i < 3) ? 8'(i + 1) : 8'd3);
    end
    checkFlags("sat.end", 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
